ntt16_top: RTL and testbench
============================

# ntt16_top

Iterative 16-point forward Number Theoretic Transform over Z_q. It captures 16 parallel coefficients on a `start` pulse and bit-reverse permutes them (`bitrev`). It then applies four radix-2 Cooley-Tukey DIT stages (`ntt_stage`, STAGE 1..4), one per clock, and presents the natural-order transform with a level `done` flag. It is the NTT core of the FHE polynomial-multiply datapath.

## Interface
- `DATA_WIDTH`, 16: coefficient width.
- `N`, 16: transform size; only 16 is supported.
- `MODULUS`, 17: prime q, with N dividing q-1 and q < 2^(DATA_WIDTH-1).
- `ROOT`, 3: primitive N-th root of unity mod q (w).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled on rising edges.
- `din0`..`din15` in DATA_WIDTH each: input coefficients x[0..15], held stable at the start edge.
- `dout0`..`dout15` out DATA_WIDTH each: transform X[0..15], natural order, fully reduced to [0, q-1].
- `done` out 1: level; high while dout holds a completed result.

## Operation
- Function: X[k] = sum over n of x[n]·w^(n·k) mod q, for k = 0..15.
- Inputs are reduced mod q before use, so any 16-bit value is legal.
- `bitrev` (combinational) maps output i to input rev4(i): 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
- `ntt_stage` with STAGE s (combinational):
  - m = 2^s, h = m/2, wm = w^(16/m) mod q.
  - For each block base k (step m) and each j < h: tw = wm^j, u = a[k+j], t = tw·a[k+j+h] mod q.
  - Outputs: a'[k+j] = (u+t) mod q, a'[k+j+h] = (u−t+q) mod q.
- Twiddles are elaboration-time constants computed from ROOT/MODULUS; no runtime twiddle ROM.
- Arithmetic widths:
  - Products are formed at 2·DATA_WIDTH bits before reduction.
  - Sums and differences carry one extra bit before conditional subtract.
  - Every stage output is in [0, q-1].
- Control FSM, states IDLE, RUN, DONE:
  - IDLE: on `start`, register bitrev(din mod q) into the 16-word array, set stage counter to 1, go to RUN.
  - RUN: each cycle, register ntt_stage(counter)(array) and increment the counter. After stage 4 completes, go to DONE and set done=1.
  - DONE: hold array and done. On `start`, reload as in IDLE, clear done, go to RUN.
- `start` during RUN is ignored; the running transform completes unchanged.
- dout is driven directly from the array register.

## Timing
- Reset: array all zero, so every dout = 0; done = 0; state IDLE.
- Reset mid-transform aborts it immediately (asynchronous), with the same reset values.
- With start sampled at edge E0:
  - E0: bitrev load.
  - E1..E4: stages 1..4.
  - After E4: done=1 and dout is valid.
- Latency is 4 cycles from the start edge to done high.
- done stays high until the edge after a new start is accepted, or until reset.
- Throughput: one transform per 5 cycles; start may be issued in the same cycle done is high.

## Test plan
- Reset, then start with din0..din15 = 0 → done after 4 cycles; all dout = 0.
- Impulse din0=1, others 0 → all dout = 1.
- All din = 1 → dout0 = 16, dout1..dout15 = 0.
- din1=1, others 0 → dout[k] = 3^k mod 17: 1,3,9,10,13,5,15,11,16,14,8,7,4,12,2,6.
- din = 12,15,2,3,4,5,6,7,8,9,10,11,12,13,14,15 → dout equals the combinational chain bitrev→stage1→stage2→stage3→stage4. Also check done=0 at E1..E3 and done=1 after E4.
- Unreduced inputs (e.g. din0=18, din1=35) must equal the result for din0=1, din1=1.
- Second start while done=1 clears done for 4 cycles, then produces the new result.
- start asserted during RUN is ignored.
- rst asserted mid-RUN zeroes all outputs immediately.

Source files
------------

// File: rtl/ntt16_top.sv
// Iterative 16-point forward NTT over Z_q: bit-reversed load, then four radix-2
// DIT butterfly stages, one per clock, with a level done flag on completion.
module ntt16_top #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16,
    parameter int MODULUS    = 17,
    parameter int ROOT       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic [DATA_WIDTH-1:0] din3,
    input  logic [DATA_WIDTH-1:0] din4,
    input  logic [DATA_WIDTH-1:0] din5,
    input  logic [DATA_WIDTH-1:0] din6,
    input  logic [DATA_WIDTH-1:0] din7,
    input  logic [DATA_WIDTH-1:0] din8,
    input  logic [DATA_WIDTH-1:0] din9,
    input  logic [DATA_WIDTH-1:0] din10,
    input  logic [DATA_WIDTH-1:0] din11,
    input  logic [DATA_WIDTH-1:0] din12,
    input  logic [DATA_WIDTH-1:0] din13,
    input  logic [DATA_WIDTH-1:0] din14,
    input  logic [DATA_WIDTH-1:0] din15,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] dout2,
    output logic [DATA_WIDTH-1:0] dout3,
    output logic [DATA_WIDTH-1:0] dout4,
    output logic [DATA_WIDTH-1:0] dout5,
    output logic [DATA_WIDTH-1:0] dout6,
    output logic [DATA_WIDTH-1:0] dout7,
    output logic [DATA_WIDTH-1:0] dout8,
    output logic [DATA_WIDTH-1:0] dout9,
    output logic [DATA_WIDTH-1:0] dout10,
    output logic [DATA_WIDTH-1:0] dout11,
    output logic [DATA_WIDTH-1:0] dout12,
    output logic [DATA_WIDTH-1:0] dout13,
    output logic [DATA_WIDTH-1:0] dout14,
    output logic [DATA_WIDTH-1:0] dout15,
    output logic                  done
);

    localparam int W2 = 2 * DATA_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam word_t Q = word_t'(MODULUS);

    function automatic int pow_mod(input int base, input int exp, input int q);
        longint acc;
        acc = 1;
        for (int i = 0; i < exp; i++) begin
            acc = (acc * longint'(base)) % longint'(q);
        end
        return int'(acc);
    endfunction

    function automatic int rev4(input int i);
        return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
    endfunction

    function automatic word_t red_in(input word_t x);
        return x % Q;
    endfunction

    function automatic word_t mul_mod(input word_t a, input word_t b);
        logic [W2-1:0] p;
        p = W2'(a) * W2'(b);
        return word_t'(p % W2'(Q));
    endfunction

    function automatic word_t add_mod(input word_t a, input word_t b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return s[DATA_WIDTH-1:0];
    endfunction

    // Adding q first keeps the difference non-negative for operands already in [0, q-1].
    function automatic word_t sub_mod(input word_t a, input word_t b);
        logic [DATA_WIDTH:0] d;
        d = {1'b0, a} + {1'b0, Q} - {1'b0, b};
        if (d >= {1'b0, Q}) d = d - {1'b0, Q};
        return d[DATA_WIDTH-1:0];
    endfunction

    word_t        din_a  [16];
    word_t        load_a [16];
    word_t        arr_q  [16];
    word_t        stg    [4][16];
    state_t       state_q;
    logic [2:0]   stage_q;
    logic [1:0]   sidx;
    logic         done_q;

    assign din_a[0]  = din0;   assign din_a[1]  = din1;
    assign din_a[2]  = din2;   assign din_a[3]  = din3;
    assign din_a[4]  = din4;   assign din_a[5]  = din5;
    assign din_a[6]  = din6;   assign din_a[7]  = din7;
    assign din_a[8]  = din8;   assign din_a[9]  = din9;
    assign din_a[10] = din10;  assign din_a[11] = din11;
    assign din_a[12] = din12;  assign din_a[13] = din13;
    assign din_a[14] = din14;  assign din_a[15] = din15;

    assign dout0  = arr_q[0];   assign dout1  = arr_q[1];
    assign dout2  = arr_q[2];   assign dout3  = arr_q[3];
    assign dout4  = arr_q[4];   assign dout5  = arr_q[5];
    assign dout6  = arr_q[6];   assign dout7  = arr_q[7];
    assign dout8  = arr_q[8];   assign dout9  = arr_q[9];
    assign dout10 = arr_q[10];  assign dout11 = arr_q[11];
    assign dout12 = arr_q[12];  assign dout13 = arr_q[13];
    assign dout14 = arr_q[14];  assign dout15 = arr_q[15];
    assign done   = done_q;

    for (genvar i = 0; i < N; i++) begin : g_bitrev
        assign load_a[i] = red_in(din_a[rev4(i)]);
    end

    // All four stages are built side by side off the array register; stage_q selects one.
    for (genvar s = 1; s <= 4; s++) begin : g_stage
        localparam int M = 1 << s;
        localparam int H = M / 2;
        for (genvar b = 0; b < 8; b++) begin : g_bf
            localparam int    J  = b % H;
            localparam int    K  = (b / H) * M;
            localparam word_t TW = word_t'(pow_mod(ROOT, (N / M) * J, MODULUS));
            word_t t_w;
            assign t_w              = mul_mod(TW, arr_q[K+J+H]);
            assign stg[s-1][K+J]    = add_mod(arr_q[K+J], t_w);
            assign stg[s-1][K+J+H]  = sub_mod(arr_q[K+J], t_w);
        end
    end

    assign sidx = 2'(stage_q - 3'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            stage_q <= 3'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) arr_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) arr_q[i] <= load_a[i];
                        stage_q <= 3'd1;
                        done_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < 16; i++) arr_q[i] <= stg[sidx][i];
                    if (stage_q == 3'd4) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        stage_q <= stage_q + 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt16_top.sv
// Directed bench for ntt16_top (q=17, w=3) checked against a direct O(N^2) DFT model.
module tb_ntt16_top;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [15:0] din  [16];
    logic [15:0] dout [16];
    logic        done;

    int n_vec  = 0;
    int n_fail = 0;

    int P3 [16] = '{1, 3, 9, 10, 13, 5, 15, 11, 16, 14, 8, 7, 4, 12, 2, 6};

    logic [15:0] va [16];
    logic [15:0] vb [16];

    ntt16_top #(.DATA_WIDTH(16), .N(16), .MODULUS(17), .ROOT(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .din0(din[0]),   .din1(din[1]),   .din2(din[2]),   .din3(din[3]),
        .din4(din[4]),   .din5(din[5]),   .din6(din[6]),   .din7(din[7]),
        .din8(din[8]),   .din9(din[9]),   .din10(din[10]), .din11(din[11]),
        .din12(din[12]), .din13(din[13]), .din14(din[14]), .din15(din[15]),
        .dout0(dout[0]),   .dout1(dout[1]),   .dout2(dout[2]),   .dout3(dout[3]),
        .dout4(dout[4]),   .dout5(dout[5]),   .dout6(dout[6]),   .dout7(dout[7]),
        .dout8(dout[8]),   .dout9(dout[9]),   .dout10(dout[10]), .dout11(dout[11]),
        .dout12(dout[12]), .dout13(dout[13]), .dout14(dout[14]), .dout15(dout[15]),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Direct DFT: X[k] = sum x[n] * 3^(n*k) mod 17, exponent taken mod the root order 16.
    function automatic logic [31:0] ref_x(input logic [15:0] v [16], input int k);
        int unsigned acc;
        int unsigned pw;
        acc = 0;
        for (int n = 0; n < 16; n++) begin
            pw = 1;
            for (int e = 0; e < (n * k) % 16; e++) pw = (pw * 3) % 17;
            acc = (acc + (int'(v[n]) % 17) * pw) % 17;
        end
        return acc;
    endfunction

    task automatic check_model(input string tag, input logic [15:0] v [16]);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s.X[%0d]", tag, k), {16'b0, dout[k]}, ref_x(v, k));
    endtask

    task automatic run_ntt(input string tag, input logic [15:0] v [16]);
        din   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("%s.done_e0", tag), 32'(done), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("%s.done_e%0d", tag, c), 32'(done), 32'd0);
        end
        tick();
        check($sformatf("%s.done_e4", tag), 32'(done), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) din[i] = 16'd0;
        tick();
        tick();
        for (int k = 0; k < 16; k++) check($sformatf("rst.dout%0d", k), {16'b0, dout[k]}, 32'd0);
        check("rst.done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        check("idle.done", 32'(done), 32'd0);

        for (int i = 0; i < 16; i++) va[i] = 16'd0;
        run_ntt("zero", va);
        for (int k = 0; k < 16; k++) check($sformatf("zero.dout%0d", k), {16'b0, dout[k]}, 32'd0);

        va[0] = 16'd1;
        run_ntt("impulse", va);
        for (int k = 0; k < 16; k++) check($sformatf("impulse.dout%0d", k), {16'b0, dout[k]}, 32'd1);

        for (int i = 0; i < 16; i++) va[i] = 16'd1;
        run_ntt("ones", va);
        for (int k = 0; k < 16; k++)
            check($sformatf("ones.dout%0d", k), {16'b0, dout[k]}, (k == 0) ? 32'd16 : 32'd0);

        for (int i = 0; i < 16; i++) va[i] = 16'd0;
        va[1] = 16'd1;
        run_ntt("x1", va);
        for (int k = 0; k < 16; k++) check($sformatf("x1.dout%0d", k), {16'b0, dout[k]}, 32'(P3[k]));

        va = '{16'd12, 16'd15, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7,
               16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15};
        run_ntt("mixed", va);
        check_model("mixed", va);

        for (int i = 0; i < 16; i++) vb[i] = 16'd0;
        vb[0] = 16'd18;
        vb[1] = 16'd35;
        run_ntt("unred", vb);
        for (int k = 0; k < 16; k++)
            check($sformatf("unred.dout%0d", k), {16'b0, dout[k]}, 32'((1 + P3[k]) % 17));

        // Restart straight from DONE with wide, unreduced values.
        check("restart.pre_done", 32'(done), 32'd1);
        vb = '{16'hFFFF, 16'd100, 16'd7, 16'd16, 16'd17, 16'd40000, 16'd3, 16'd0,
               16'd9, 16'd1234, 16'd5, 16'd33, 16'd8, 16'hFFFE, 16'd2, 16'd11};
        run_ntt("restart", vb);
        check_model("restart", vb);
        tick();
        tick();
        tick();
        check("hold.done", 32'(done), 32'd1);
        check("hold.dout9", {16'b0, dout[9]}, ref_x(vb, 9));

        // A second start two cycles into RUN must not disturb the transform.
        din   = va;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        din   = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ignore.done_e2", 32'(done), 32'd0);
        tick();
        check("ignore.done_e3", 32'(done), 32'd0);
        tick();
        check("ignore.done_e4", 32'(done), 32'd1);
        check_model("ignore", va);
        tick();
        check("ignore.stay_done", 32'(done), 32'd1);

        for (int i = 0; i < 16; i++) va[i] = 16'd1;
        din   = va;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 16; k++) check($sformatf("midrst.dout%0d", k), {16'b0, dout[k]}, 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        check("postrst.done", 32'(done), 32'd0);
        check("postrst.dout0", {16'b0, dout[0]}, 32'd0);

        for (int i = 0; i < 16; i++) va[i] = 16'd0;
        va[0] = 16'd1;
        run_ntt("recover", va);
        for (int k = 0; k < 16; k++) check($sformatf("recover.dout%0d", k), {16'b0, dout[k]}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
